// File: rtl/link_test_sequencer_if.sv
// Control, status and bit-compare signals between the link test sequencer and its driver.
// master drives run requests and bit stream; slave is the sequencer.
interface link_test_sequencer_if;
  logic        start;
  logic        sweep;
  logic [3:0]  ber_sel;
  logic        abort;
  logic        bit_tick;
  logic        ref_bit;
  logic        rx_bit;
  logic        init_tab;
  logic        IsTransmit;
  logic [3:0]  BER;
  logic        busy;
  logic        frame_done;
  logic [15:0] err_out;
  logic [3:0]  frame_ber;
  logic        run_done;

  modport master (
    output start, sweep, ber_sel, abort, bit_tick, ref_bit, rx_bit,
    input  init_tab, IsTransmit, BER, busy, frame_done, err_out, frame_ber, run_done
  );

  modport slave (
    input  start, sweep, ber_sel, abort, bit_tick, ref_bit, rx_bit,
    output init_tab, IsTransmit, BER, busy, frame_done, err_out, frame_ber, run_done
  );
endinterface

// File: rtl/link_test_sequencer.sv
// Run controller: table init, transmit gating, BER stepping/sweep and per-frame bit-error count.
// Registered outputs, one cycle after the deciding input; no backpressure, abort wins everywhere.
module link_test_sequencer #(
  parameter int INIT_CYCLES = 64,
  parameter int FLUSH_BITS  = 32,
  parameter int FRAME_BITS  = 1024,
  parameter int REF_DELAY   = 8
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  link_test_sequencer_if.slave lt
);

  typedef enum logic [2:0] {IDLE, INIT, FLUSH, MEASURE, FRAME_END, FINISH} state_t;

  localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CW-1:0] INIT_LOAD  = CW'(INIT_CYCLES - 1);
  localparam logic [15:0]   FLUSH_LAST = 16'(FLUSH_BITS - 1);
  localparam logic [15:0]   FRAME_LAST = 16'(FRAME_BITS - 1);

  state_t        state, state_d;
  logic [CW-1:0] cyc_cnt;
  logic [15:0]   bit_cnt;
  logic [15:0]   acc, acc_d;
  logic [63:0]   dline;
  logic          dline_unused;
  logic          sweep_q;
  logic [3:0]    ber_q, frame_ber_q;
  logic [15:0]   err_q;
  logic          busy_q, init_q, tx_q, fdone_q, rdone_q;
  logic          busy_d, init_d, tx_d, fdone_d, rdone_d;
  logic          mismatch;

  assign dline_unused = dline[63];
  assign mismatch     = lt.bit_tick && (lt.rx_bit != dline[REF_DELAY-1]);

  always_comb begin
    acc_d = acc;
    if (state == MEASURE && mismatch && acc != 16'hFFFF)
      acc_d = acc + 16'd1;
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (lt.abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:      if (lt.start) state_d = INIT;
        INIT:      if (cyc_cnt == '0) state_d = FLUSH;
        FLUSH:     if (lt.bit_tick && bit_cnt == FLUSH_LAST) state_d = MEASURE;
        MEASURE:   if (lt.bit_tick && bit_cnt == FRAME_LAST) state_d = FRAME_END;
        FRAME_END: state_d = (sweep_q && ber_q != 4'hF) ? FLUSH : FINISH;
        FINISH:    state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they land in the same cycle as the state.
  always_comb begin
    busy_d  = (state_d != IDLE);
    init_d  = (state_d == INIT);
    tx_d    = (state_d == FLUSH) || (state_d == MEASURE) || (state_d == FRAME_END);
    fdone_d = (state_d == FRAME_END);
    rdone_d = (state_d == FINISH);
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      acc         <= '0;
      dline       <= '0;
      sweep_q     <= 1'b0;
      ber_q       <= '0;
      frame_ber_q <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      init_q      <= 1'b0;
      tx_q        <= 1'b0;
      fdone_q     <= 1'b0;
      rdone_q     <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      init_q  <= init_d;
      tx_q    <= tx_d;
      fdone_q <= fdone_d;
      rdone_q <= rdone_d;

      if (lt.bit_tick) dline <= {dline[62:0], lt.ref_bit};

      if (state == IDLE && state_d == INIT) begin
        cyc_cnt <= INIT_LOAD;
        sweep_q <= lt.sweep;
        ber_q   <= lt.sweep ? 4'd0 : lt.ber_sel;
      end else if (state == INIT && cyc_cnt != '0) begin
        cyc_cnt <= cyc_cnt - CW'(1);
      end

      // A tick on the leaving edge belongs to the old state; the new state starts from zero.
      if (state_d != state)
        bit_cnt <= '0;
      else if ((state == FLUSH || state == MEASURE) && lt.bit_tick)
        bit_cnt <= bit_cnt + 16'd1;

      if (state == FLUSH) acc <= '0;
      else                acc <= acc_d;

      if (state == MEASURE && state_d == FRAME_END) begin
        err_q       <= acc_d;
        frame_ber_q <= ber_q;
      end

      if (state == FRAME_END && state_d == FLUSH)
        ber_q <= ber_q + 4'd1;
    end
  end

  assign lt.init_tab   = init_q;
  assign lt.IsTransmit = tx_q;
  assign lt.BER        = ber_q;
  assign lt.busy       = busy_q;
  assign lt.frame_done = fdone_q;
  assign lt.err_out    = err_q;
  assign lt.frame_ber  = frame_ber_q;
  assign lt.run_done   = rdone_q;

endmodule

// File: tb/tb_link_test_sequencer.sv
// Randomized bench for link_test_sequencer: bit-level stimulus with a tick-history model and a frame scoreboard.
module tb_link_test_sequencer;
  localparam int INIT_C  = 64;
  localparam int FLUSH_B = 32;
  localparam int FRAME_B = 1024;
  localparam int DLY     = 8;

  typedef struct {
    logic [15:0] err;
    logic [3:0]  ber;
    bit          last;
  } exp_t;

  logic sys_clk = 1'b0;
  logic reset;
  logic sat_reset;
  always #5 sys_clk = ~sys_clk;

  link_test_sequencer_if lt();
  link_test_sequencer_if st();

  link_test_sequencer dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .lt      (lt)
  );

  link_test_sequencer #(
    .INIT_CYCLES (4),
    .FLUSH_BITS  (4),
    .FRAME_BITS  (65535),
    .REF_DELAY   (DLY)
  ) dut_sat (
    .sys_clk (sys_clk),
    .reset   (sat_reset),
    .lt      (st)
  );

  int   total = 0;
  int   bad   = 0;
  int   runs_exp  = 0;
  int   runs_seen = 0;
  bit   mon_en = 0;
  exp_t exp_q[$];
  bit   hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},       32'(lt.busy),       0);
    chk({tag, "_init_tab"},   32'(lt.init_tab),   0);
    chk({tag, "_IsTransmit"}, 32'(lt.IsTransmit), 0);
    chk({tag, "_BER"},        32'(lt.BER),        0);
    chk({tag, "_err_out"},    32'(lt.err_out),    0);
    chk({tag, "_frame_ber"},  32'(lt.frame_ber),  0);
    chk({tag, "_frame_done"}, 32'(lt.frame_done), 0);
    chk({tag, "_run_done"},   32'(lt.run_done),   0);
  endtask

  task automatic clear_hist();
    hist = {};
    repeat (64) hist.push_back(1'b0);
  endtask

  // Drive one cycle at the negedge; on a tick, rx is the reference from DLY ticks back, optionally inverted.
  task automatic step(input bit tick, input bit inj);
    bit r;
    lt.bit_tick = tick;
    if (tick) begin
      r = 1'($urandom_range(0, 1));
      lt.ref_bit = r;
      lt.rx_bit  = hist[hist.size() - DLY] ^ inj;
      hist.push_back(r);
      void'(hist.pop_front());
    end else begin
      lt.ref_bit = 1'($urandom_range(0, 1));
      lt.rx_bit  = 1'($urandom_range(0, 1));
    end
    @(negedge sys_clk);
    lt.start = 1'b0;
    lt.abort = 1'b0;
  endtask

  task automatic tick_step(input bit inj);
    while ($urandom_range(0, 3) == 0) step(1'b0, 1'b0);
    step(1'b1, inj);
  endtask

  task automatic run(input bit sw, input logic [3:0] sel, input int n_err, input int n_flush_err,
                     input int abort_frame, input bit do_reset, input bit stray_start);
    int         nfr;
    int         cnt;
    int         errs;
    int         idx;
    int         last_err;
    logic [3:0] ber;
    bit         inj[FRAME_B];
    last_err = 0;
    lt.start   = 1'b1;
    lt.sweep   = sw;
    lt.ber_sel = sel;
    step(1'($urandom_range(0, 1)), 1'b0);
    lt.sweep   = 1'($urandom_range(0, 1));
    lt.ber_sel = 4'($urandom_range(0, 15));
    repeat (INIT_C) step(1'($urandom_range(0, 1)), 1'b0);
    ber = sw ? 4'd0 : sel;
    nfr = sw ? 16 : 1;
    for (int f = 0; f < nfr; f++) begin
      for (int k = 0; k < FLUSH_B; k++) begin
        if (stray_start && f == 0 && k == 10) begin
          lt.start   = 1'b1;
          lt.sweep   = ~sw;
          lt.ber_sel = ber + 4'd7;
        end
        tick_step(k < n_flush_err);
      end
      for (int i = 0; i < FRAME_B; i++) inj[i] = 1'b0;
      cnt  = (n_err < 0) ? int'($urandom_range(0, 60)) : n_err;
      errs = 0;
      while (errs < cnt) begin
        idx = int'($urandom_range(0, FRAME_B - 1));
        if (!inj[idx]) begin
          inj[idx] = 1'b1;
          errs++;
        end
      end
      for (int i = 0; i < FRAME_B; i++) begin
        if (abort_frame == f && i == FRAME_B / 2) begin
          lt.abort = 1'b1;
          step(1'b1, inj[i]);
          chk("abort_IsTransmit", 32'(lt.IsTransmit), 0);
          chk("abort_init_tab",   32'(lt.init_tab),   0);
          chk("abort_busy",       32'(lt.busy),       0);
          chk("abort_err_hold",   32'(lt.err_out),    32'(last_err));
          lt.start = 1'b1;
          lt.abort = 1'b1;
          step(1'b0, 1'b0);
          chk("abort_start_busy", 32'(lt.busy), 0);
          return;
        end
        if (do_reset && i == 300) begin
          #2 reset = 1'b0;
          #1 chk_idle("midreset");
          @(negedge sys_clk);
          @(negedge sys_clk);
          reset = 1'b1;
          clear_hist();
          for (int j = 0; j < 5; j++) begin
            step(1'($urandom_range(0, 1)), 1'b0);
            chk("post_reset_busy", 32'(lt.busy), 0);
          end
          return;
        end
        if (i == FRAME_B - 1) exp_q.push_back('{err: 16'(errs), ber: ber, last: (f == nfr - 1)});
        tick_step(inj[i]);
      end
      last_err = errs;
      step(1'($urandom_range(0, 1)), 1'b0);
      if (f < nfr - 1) ber = ber + 4'd1;
    end
    step(1'($urandom_range(0, 1)), 1'b0);
    runs_exp++;
  endtask

  // Monitor: pops the scoreboard on frame_done and checks the cycle after each frame.
  exp_t       m_e;
  bit         prev_fd, prev_last, prev_rd, prev_init;
  logic [3:0] prev_ber, ber_next;
  int         init_len;

  always @(negedge sys_clk) begin
    if (!reset) begin
      prev_fd = 0; prev_last = 0; prev_rd = 0; prev_init = 0; init_len = 0;
    end else if (mon_en) begin
      if (lt.frame_done) begin
        chk("frame_done_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          m_e = exp_q.pop_front();
          chk("err_out",   32'(lt.err_out),   32'(m_e.err));
          chk("frame_ber", 32'(lt.frame_ber), 32'(m_e.ber));
          prev_last = m_e.last;
          prev_ber  = m_e.ber;
        end
      end
      if (prev_fd) begin
        chk("run_done_after_frame", 32'(lt.run_done),   32'(prev_last));
        chk("tx_after_frame",       32'(lt.IsTransmit), 32'(!prev_last));
        if (!prev_last) begin
          ber_next = prev_ber + 4'd1;
          chk("ber_step", 32'(lt.BER), 32'(ber_next));
        end
      end
      if (lt.run_done) begin
        chk("run_done_follows_frame", 32'(prev_fd), 1);
        runs_seen++;
      end
      if (prev_rd) chk("busy_after_run", 32'(lt.busy), 0);
      if (lt.init_tab) begin
        init_len++;
      end else if (prev_init) begin
        chk("init_len", 32'(init_len), 32'(INIT_C));
        chk("tx_rise",  32'(lt.IsTransmit), 1);
        init_len = 0;
      end
      prev_fd   = lt.frame_done;
      prev_rd   = lt.run_done;
      prev_init = lt.init_tab;
    end
  end

  task automatic main_seq();
    logic [3:0] s;
    clear_hist();
    lt.start = 0; lt.sweep = 0; lt.ber_sel = 0; lt.abort = 0;
    lt.bit_tick = 0; lt.ref_bit = 0; lt.rx_bit = 0;
    reset = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk_idle("reset");
    reset = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("idle_busy", 32'(lt.busy), 0);
    mon_en = 1;
    run(1'b0, 4'd5, 0, 0, -1, 1'b0, 1'b0);
    run(1'b0, 4'd9, 37, 5, -1, 1'b0, 1'b0);
    s = 4'($urandom_range(0, 15));
    run(1'b0, s, -1, 3, -1, 1'b0, 1'b0);
    run(1'b1, 4'd0, 0, 0, -1, 1'b0, 1'b0);
    run(1'b1, 4'd11, -1, 2, 2, 1'b0, 1'b1);
    run(1'b0, 4'd7, -1, 0, -1, 1'b1, 1'b0);
    run(1'b0, 4'd12, -1, 4, -1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0);
  endtask

  task automatic sat_seq();
    bit sh[$];
    bit r;
    bit got;
    repeat (64) sh.push_back(1'b0);
    st.start = 0; st.sweep = 0; st.ber_sel = 0; st.abort = 0;
    st.bit_tick = 0; st.ref_bit = 0; st.rx_bit = 0;
    sat_reset = 1'b0;
    repeat (3) @(negedge sys_clk);
    sat_reset = 1'b1;
    @(negedge sys_clk);
    st.start   = 1'b1;
    st.ber_sel = 4'd3;
    got = 0;
    for (int c = 0; c < 70000 && !got; c++) begin
      r = 1'($urandom_range(0, 1));
      st.bit_tick = 1'b1;
      st.ref_bit  = r;
      st.rx_bit   = ~sh[sh.size() - DLY];
      sh.push_back(r);
      void'(sh.pop_front());
      @(negedge sys_clk);
      st.start = 1'b0;
      if (st.frame_done) got = 1;
    end
    st.bit_tick = 1'b0;
    chk("sat_frame_done_seen", 32'(got), 1);
    chk("sat_err_out",   32'(st.err_out),   32'h0000_FFFF);
    chk("sat_frame_ber", 32'(st.frame_ber), 3);
  endtask

  initial begin
    fork
      main_seq();
      sat_seq();
    join
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    chk("run_done_count", 32'(runs_seen), 32'(runs_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
